// File: rtl/scan_loader.sv
// Scan-chain loader: shifts parallel words MSB first into the filter scan chain and,
// when SCAN_READBACK_EN is defined, captures the bits returned on the chain output.
// Without SCAN_READBACK_EN the capture path is absent and rdata_out/rvalid_out stay 0.
module scan_loader #(
   parameter int unsigned DATABITS = 16,
   parameter int unsigned NWORDS   = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_in,
   input  logic                abort_in,
   input  logic [DATABITS-1:0] wdata_in,
   input  logic                wvalid_in,
   output logic                wready_out,
   output logic                sde_out,
   output logic                sd_out,
   input  logic                sd_in,
   output logic [DATABITS-1:0] rdata_out,
   output logic                rvalid_out,
   output logic                busy_out,
   output logic                done_out
);

   localparam int unsigned BitW  = (DATABITS > 1) ? $clog2(DATABITS) : 1;
   localparam int unsigned WordW = $clog2(NWORDS + 1);
   localparam logic [BitW-1:0]  BitLast = BitW'(DATABITS - 1);
   localparam logic [WordW-1:0] WordMax = WordW'(NWORDS);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e              state_q, state_d;
   logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [WordW-1:0]    word_cnt_q, word_cnt_d;
   logic [DATABITS-1:0] shift_q, shift_d;
   logic                sd_q, sd_d;
   logic                sde_q, sde_d;
   logic                wready_q, wready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                handshake;
   logic                last_bit;

   assign handshake = (state_q == StLoad) && wvalid_in && wready_q;
   assign last_bit  = (state_q == StShift) && (bit_cnt_q == BitLast);

   // Next-state, counters and registered-output decode; abort overrides every transition.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      case (state_q)
         StIdle: begin
            if (start_in) begin
               state_d    = StLoad;
               word_cnt_d = '0;
            end
         end
         StLoad: begin
            if (handshake) begin
               state_d   = StShift;
               bit_cnt_d = '0;
            end
         end
         StShift: begin
            if (last_bit) begin
               bit_cnt_d  = '0;
               word_cnt_d = (word_cnt_q == WordMax) ? word_cnt_q : word_cnt_q + WordW'(1);
               state_d    = (word_cnt_d < WordMax) ? StLoad : StDone;
            end else begin
               bit_cnt_d = bit_cnt_q + BitW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (abort_in) begin
         state_d = StIdle;
      end

      wready_d = (state_d == StLoad);
      sde_d    = (state_d == StShift);
      busy_d   = (state_d == StLoad) || (state_d == StShift);
      done_d   = (state_d == StDone);
   end

   // Serialiser: first bit goes out straight from wdata_in, the rest from the shift register.
   always_comb begin
      shift_d = shift_q;
      sd_d    = 1'b0;
      if (handshake) begin
         shift_d = wdata_in << 1;
         sd_d    = wdata_in[DATABITS-1];
      end else if ((state_q == StShift) && !last_bit) begin
         shift_d = shift_q << 1;
         sd_d    = shift_q[DATABITS-1];
      end
      // Keep sd_out quiet whenever the chain is not being shifted.
      sd_d = sd_d && (state_d == StShift);
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         shift_q    <= '0;
         sd_q       <= 1'b0;
         sde_q      <= 1'b0;
         wready_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         shift_q    <= shift_d;
         sd_q       <= sd_d;
         sde_q      <= sde_d;
         wready_q   <= wready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign wready_out = wready_q;
   assign sde_out    = sde_q;
   assign sd_out     = sd_q;
   assign busy_out   = busy_q;
   assign done_out   = done_q;

`ifdef SCAN_READBACK_EN
   logic [DATABITS-1:0] cap_q, cap_d;
   logic [DATABITS-1:0] rdata_q, rdata_d;
   logic                rvalid_q, rvalid_d;

   // Capture returned bits LSB-side; publish the word once its last bit has arrived.
   always_comb begin
      cap_d    = cap_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (state_q == StShift) begin
         cap_d = {cap_q[DATABITS-2:0], sd_in};
      end
      if (last_bit && !abort_in) begin
         rdata_d  = cap_d;
         rvalid_d = 1'b1;
      end
   end

   // Capture and readback registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         cap_q    <= cap_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rdata_out  = rdata_q;
   assign rvalid_out = rvalid_q;
`else
   logic unused_sd_in;
   assign unused_sd_in = sd_in;
   assign rdata_out    = '0;
   assign rvalid_out   = 1'b0;
`endif

endmodule

// File: tb/tb_scan_loader.sv
// Directed bench for scan_loader (DATABITS=16, NWORDS=4) with a 64-bit scan chain model.
module tb_scan_loader;

   localparam int unsigned DW = 16;
   localparam int unsigned NW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_in;
   logic          abort_in;
   logic [DW-1:0] wdata_in;
   logic          wvalid_in;
   logic          wready_out;
   logic          sde_out;
   logic          sd_out;
   logic          sd_in;
   logic [DW-1:0] rdata_out;
   logic          rvalid_out;
   logic          busy_out;
   logic          done_out;

   int checks   = 0;
   int failures = 0;

   scan_loader #(.DATABITS(DW), .NWORDS(NW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_in   (start_in),
      .abort_in   (abort_in),
      .wdata_in   (wdata_in),
      .wvalid_in  (wvalid_in),
      .wready_out (wready_out),
      .sde_out    (sde_out),
      .sd_out     (sd_out),
      .sd_in      (sd_in),
      .rdata_out  (rdata_out),
      .rvalid_out (rvalid_out),
      .busy_out   (busy_out),
      .done_out   (done_out)
   );

   always #5 clk = ~clk;

   // Chain model: shifts only while sde_out is high, returns its MSB.
   logic [63:0] chain;
   logic        preload_req = 1'b0;
   logic [63:0] preload_val = '0;
   always @(posedge clk) begin
      if (preload_req) chain <= preload_val;
      else if (sde_out) chain <= {chain[62:0], sd_out};
   end
   assign sd_in = chain[63];

   // Monitor of word-level pulses.
   int          rv_cnt   = 0;
   int          done_cnt = 0;
   logic [DW-1:0] rq[$];
   always @(negedge clk) begin
      if (rvalid_out === 1'b1) begin
         rv_cnt++;
         rq.push_back(rdata_out);
      end
      if (done_out === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
   endtask

   // Offer one word and return in the first SHIFT cycle; ok=0 if wready never came.
   task automatic push_word(input logic [DW-1:0] d, output bit ok);
      wdata_in  = d;
      wvalid_in = 1'b1;
      ok        = 1'b0;
      for (int n = 0; n < 64; n++) begin
         if (wready_out === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) tick();
      wvalid_in = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 80; n++) begin
         tick();
         if (done_out === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_in = 1'b0; abort_in = 1'b0; wdata_in = '0; wvalid_in = 1'b0;
      tick();
      preload_val = 64'hA5A5_5A5A_0F0F_F0F0;
      preload_req = 1'b1;
      tick();
      preload_req = 1'b0;
      checks++; if (wready_out !== 1'b0) begin failures++; $display("FAIL rst_wready: got %b want 0", wready_out); end
      checks++; if (sde_out !== 1'b0) begin failures++; $display("FAIL rst_sde: got %b want 0", sde_out); end
      checks++; if (sd_out !== 1'b0) begin failures++; $display("FAIL rst_sd: got %b want 0", sd_out); end
      checks++; if (rdata_out !== '0) begin failures++; $display("FAIL rst_rdata: got %h want 0", rdata_out); end
      checks++; if (rvalid_out !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %b want 0", rvalid_out); end
      checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy_out); end
      checks++; if (done_out !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done_out); end
      rst_n = 1'b1;
      tick();
      tick();
      checks++; if ({wready_out, busy_out} !== 2'b00) begin failures++; $display("FAIL idle_after_rst: got %b want 00", {wready_out, busy_out}); end
   endtask

   // Full load with wvalid held high; checks every serial bit and word-level pulses.
   task automatic test_stream();
      logic [DW-1:0] w [NW] = '{16'h8001, 16'h1234, 16'hFFFF, 16'h0000};
      logic [DW-1:0] rb [NW] = '{16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0};
      int cyc = 0;
      pulse_start();
      checks++; if ({wready_out, busy_out, sde_out} !== 3'b110) begin failures++; $display("FAIL load_entry: got %b want 110", {wready_out, busy_out, sde_out}); end
      wvalid_in = 1'b1;
      for (int k = 0; k < NW; k++) begin
         wdata_in = w[k];
         checks++; if (wready_out !== 1'b1) begin failures++; $display("FAIL hs_ready w%0d: got %b want 1", k, wready_out); end
         for (int i = 0; i < DW; i++) begin
            tick();
            cyc++;
            checks++;
            if ({sde_out, sd_out, wready_out, rvalid_out} !== {1'b1, w[k][DW-1-i], 2'b00}) begin
               failures++;
               $display("FAIL shift w%0d b%0d: got sde/sd/wr/rv=%b want %b", k, i,
                        {sde_out, sd_out, wready_out, rvalid_out}, {1'b1, w[k][DW-1-i], 2'b00});
            end
         end
         tick();
         cyc++;
         checks++; if (sde_out !== 1'b0) begin failures++; $display("FAIL gap_sde w%0d: got %b want 0", k, sde_out); end
`ifdef SCAN_READBACK_EN
         checks++; if ({rvalid_out, rdata_out} !== {1'b1, rb[k]}) begin failures++; $display("FAIL readback w%0d: got rv=%b %h want rv=1 %h", k, rvalid_out, rdata_out, rb[k]); end
`else
         checks++; if ({rvalid_out, rdata_out} !== 17'h0) begin failures++; $display("FAIL no_readback w%0d: got rv=%b %h want 0", k, rvalid_out, rdata_out); end
`endif
         if (k < NW - 1) begin
            checks++; if ({wready_out, busy_out, done_out} !== 3'b110) begin failures++; $display("FAIL gap_ctl w%0d: got %b want 110", k, {wready_out, busy_out, done_out}); end
         end else begin
            checks++; if ({wready_out, busy_out, done_out} !== 3'b001) begin failures++; $display("FAIL done_ctl: got %b want 001", {wready_out, busy_out, done_out}); end
            checks++; if (cyc !== 68) begin failures++; $display("FAIL done_cycle: got %0d want 68", cyc); end
         end
      end
      wvalid_in = 1'b0;
      tick();
      checks++; if ({busy_out, done_out, wready_out, sde_out, rvalid_out} !== 5'b0) begin failures++; $display("FAIL post_done: got %b want 00000", {busy_out, done_out, wready_out, sde_out, rvalid_out}); end
`ifdef SCAN_READBACK_EN
      checks++; if (rdata_out !== 16'hF0F0) begin failures++; $display("FAIL rdata_hold: got %h want f0f0", rdata_out); end
`else
      checks++; if (rdata_out !== 16'h0) begin failures++; $display("FAIL rdata_tied: got %h want 0", rdata_out); end
`endif
      checks++; if (chain !== 64'h8001_1234_FFFF_0000) begin failures++; $display("FAIL chain_load1: got %h want 8001_1234_ffff_0000", chain); end
   endtask

   // Second load reads back the words written by the first.
   task automatic test_second_load();
      logic [DW-1:0] w [NW] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      logic [DW-1:0] rb [NW] = '{16'h8001, 16'h1234, 16'hFFFF, 16'h0000};
      int base = rq.size(); int rv0 = rv_cnt; int d0 = done_cnt; bit ok; bit all_ok = 1'b1;
      pulse_start();
      for (int k = 0; k < NW; k++) begin push_word(w[k], ok); all_ok &= ok; end
      wait_done(ok); all_ok &= ok;
      tick();
      checks++; if (all_ok !== 1'b1) begin failures++; $display("FAIL load2_timeout: got %b want 1", all_ok); end
      checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL load2_done: got %0d want 1", done_cnt - d0); end
`ifdef SCAN_READBACK_EN
      checks++; if (rv_cnt - rv0 !== NW) begin failures++; $display("FAIL load2_rvcnt: got %0d want %0d", rv_cnt - rv0, NW); end
      for (int k = 0; k < NW; k++) begin
         checks++; if (rq.size() <= base + k || rq[base + k] !== rb[k]) begin failures++; $display("FAIL load2_rb w%0d: got %h want %h", k, (rq.size() > base + k) ? rq[base + k] : 16'hxxxx, rb[k]); end
      end
`else
      checks++; if (rv_cnt - rv0 !== 0) begin failures++; $display("FAIL load2_rvcnt: got %0d want 0", rv_cnt - rv0); end
`endif
      checks++; if (chain !== 64'h1111_2222_3333_4444) begin failures++; $display("FAIL chain_load2: got %h want 1111_2222_3333_4444", chain); end
   endtask

   // wvalid low for 10 cycles between words 2 and 3.
   task automatic test_stall();
      logic [DW-1:0] w [NW] = '{16'hCAFE, 16'hBEEF, 16'h0123, 16'h4567};
      logic [63:0] snap; int d0 = done_cnt; bit ok; bit all_ok = 1'b1; bit seen = 1'b0;
      pulse_start();
      push_word(w[0], ok); all_ok &= ok;
      push_word(w[1], ok); all_ok &= ok;
      for (int n = 0; n < 40; n++) begin
         if (wready_out === 1'b1) begin seen = 1'b1; break; end
         tick();
      end
      all_ok &= seen;
      snap = chain;
      for (int j = 0; j < 10; j++) begin
         checks++; if ({sde_out, wready_out, busy_out} !== 3'b011) begin failures++; $display("FAIL stall c%0d: got sde/wr/busy=%b want 011", j, {sde_out, wready_out, busy_out}); end
         tick();
      end
      checks++; if (chain !== snap) begin failures++; $display("FAIL stall_chain: got %h want %h", chain, snap); end
      push_word(w[2], ok); all_ok &= ok;
      push_word(w[3], ok); all_ok &= ok;
      wait_done(ok); all_ok &= ok;
      tick();
      checks++; if (all_ok !== 1'b1) begin failures++; $display("FAIL stall_timeout: got %b want 1", all_ok); end
      checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL stall_done: got %0d want 1", done_cnt - d0); end
      checks++; if (chain !== 64'hCAFE_BEEF_0123_4567) begin failures++; $display("FAIL stall_chainfinal: got %h want cafe_beef_0123_4567", chain); end
   endtask

   // Abort in the 7th SHIFT cycle of word 2, then a clean reload.
   task automatic test_abort();
      logic [DW-1:0] w [NW] = '{16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00};
      int rv0 = rv_cnt; int d0 = done_cnt; bit ok; bit all_ok = 1'b1;
      pulse_start();
      push_word(16'h1357, ok); all_ok &= ok;
      push_word(16'h2468, ok); all_ok &= ok;
      for (int j = 0; j < 6; j++) tick();
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;
      checks++; if ({sde_out, busy_out, wready_out, done_out, rvalid_out} !== 5'b0) begin failures++; $display("FAIL abort_out: got %b want 00000", {sde_out, busy_out, wready_out, done_out, rvalid_out}); end
      tick();
      tick();
      checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL abort_done: got %0d want 0", done_cnt - d0); end
`ifdef SCAN_READBACK_EN
      checks++; if (rv_cnt - rv0 !== 1) begin failures++; $display("FAIL abort_rvcnt: got %0d want 1", rv_cnt - rv0); end
`else
      checks++; if (rv_cnt - rv0 !== 0) begin failures++; $display("FAIL abort_rvcnt: got %0d want 0", rv_cnt - rv0); end
`endif
      rv0 = rv_cnt;
      pulse_start();
      for (int k = 0; k < NW; k++) begin push_word(w[k], ok); all_ok &= ok; end
      wait_done(ok); all_ok &= ok;
      tick();
      checks++; if (all_ok !== 1'b1) begin failures++; $display("FAIL abort_timeout: got %b want 1", all_ok); end
      checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL reload_done: got %0d want 1", done_cnt - d0); end
`ifdef SCAN_READBACK_EN
      checks++; if (rv_cnt - rv0 !== NW) begin failures++; $display("FAIL reload_rvcnt: got %0d want %0d", rv_cnt - rv0, NW); end
`endif
      checks++; if (chain !== 64'h0F0F_F0F0_00FF_FF00) begin failures++; $display("FAIL reload_chain: got %h want 0f0f_f0f0_00ff_ff00", chain); end
   endtask

   // Asynchronous reset in the middle of SHIFT.
   task automatic test_reset_mid();
      bit ok;
      pulse_start();
      push_word(16'hAAAA, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstmid_hs: got %b want 1", ok); end
      for (int j = 0; j < 4; j++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wready_out, sde_out, sd_out, rvalid_out, busy_out, done_out, rdata_out} !== 22'h0) begin
         failures++;
         $display("FAIL rstmid_async: got %b_%h want all 0", {wready_out, sde_out, sd_out, rvalid_out, busy_out, done_out}, rdata_out);
      end
      tick();
      rst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         checks++; if ({wready_out, busy_out, sde_out} !== 3'b000) begin failures++; $display("FAIL rstmid_idle c%0d: got %b want 000", j, {wready_out, busy_out, sde_out}); end
      end
      pulse_start();
      checks++; if (wready_out !== 1'b1) begin failures++; $display("FAIL rstmid_restart: got %b want 1", wready_out); end
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;
      checks++; if ({wready_out, busy_out} !== 2'b00) begin failures++; $display("FAIL rstmid_abort: got %b want 00", {wready_out, busy_out}); end
   endtask

   // start_in held through the load and the DONE cycle must not restart.
   task automatic test_start_ignored();
      int d0 = done_cnt; bit ok; bit all_ok = 1'b1;
      start_in = 1'b1;
      tick();
      for (int k = 0; k < NW; k++) begin push_word(16'h5A00 + 16'(k), ok); all_ok &= ok; end
      wait_done(ok); all_ok &= ok;
      tick();
      start_in = 1'b0;
      checks++; if (all_ok !== 1'b1) begin failures++; $display("FAIL hold_timeout: got %b want 1", all_ok); end
      for (int j = 0; j < 5; j++) begin
         checks++; if ({wready_out, busy_out, sde_out} !== 3'b000) begin failures++; $display("FAIL hold_idle c%0d: got %b want 000", j, {wready_out, busy_out, sde_out}); end
         tick();
      end
      checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL hold_done: got %0d want 1", done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_second_load();
      test_stall();
      test_abort();
      test_reset_mid();
      test_start_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/scan_loader.md
Name: scan_loader

Overview:
- Host-side driver for the filter unit's coefficient/data scan chain.
- Accepts parallel words on a valid/ready port and shifts each one serially, MSB first, into the chain input. It drives the chain's scan-enable and scan-data inputs.
- At the same time it captures the bits returned on the chain output, which gives readback of the previous chain contents.
- Sits outside filter_unit, next to the test/configuration controller.

Parameters:
DATABITS, 16, width of one scan word (matches myfilter_pkg DATABITS)
NWORDS, 32, number of words per full chain load (chain length = NWORDS*DATABITS bits)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_in  in  1  start a chain load; sampled only in IDLE
abort_in  in  1  abandon current load, return to IDLE
wdata_in  in  DATABITS  word to shift into chain
wvalid_in  in  1  wdata_in valid
wready_out  out  1  loader can accept a word
sde_out  out  1  scan enable to filter sde_in
sd_out  out  1  scan data to filter sd_in
sd_in  in  1  scan data from filter sd_out
rdata_out  out  DATABITS  word captured from chain output
rvalid_out  out  1  one-cycle pulse, rdata_out valid
busy_out  out  1  load in progress
done_out  out  1  one-cycle pulse, full chain loaded

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Takes effect immediately when rst_n falls, including mid-shift; sde_out drops at once and the partial word is discarded.
- All outputs are registered.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - busy_out=0, wready_out=0.
  - start_in=1 -> LOAD next cycle, word counter cleared.
- LOAD:
  - busy_out=1, wready_out=1, sde_out=0.
  - On wvalid_in&wready_out at edge t: word loaded into shift register, -> SHIFT.
- SHIFT:
  - Lasts exactly DATABITS cycles (t+1 .. t+DATABITS).
  - sde_out=1 throughout. sd_out = wdata[DATABITS-1-i] in cycle t+1+i.
  - wready_out=0.
  - sd_in is sampled at the rising edge ending each SHIFT cycle and shifted into the capture register LSB-side. The first bit captured ends in bit DATABITS-1.
  - After the last bit: word counter increments. -> LOAD if the count is below NWORDS, else -> DONE.
- Word-level timing:
  - The capture word is presented on rdata_out with rvalid_out=1 for one cycle, the cycle after the last SHIFT cycle (t+DATABITS+1).
  - Max throughput: one word per DATABITS+1 cycles. sde_out is low for at least one cycle between words and the chain holds its contents while sde_out=0.
- DONE:
  - Lasts one cycle. done_out=1, busy_out=0, -> IDLE.
  - rvalid_out for the final word coincides with done_out.
- start_in while busy is ignored. start_in asserted in the DONE cycle is also ignored.
- abort_in has priority over all transitions:
  - Any state -> IDLE next edge; sde_out=0 at that edge.
  - No rvalid_out and no done_out are issued for the partial word.
  - Chain contents are then undefined.
- wvalid_in may drop in LOAD with no handshake; the loader waits indefinitely with sde_out=0.
- Counters:
  - Bit counter is clog2(DATABITS) bits wide. It wraps to 0 at the end of each word.
  - Word counter is clog2(NWORDS+1) bits wide and saturates at NWORDS.
- rdata_out holds its last value between rvalid_out pulses.

Optional Feature:
- Macro SCAN_READBACK_EN.
- Defined: capture register, rdata_out and rvalid_out behave as above.
- Not defined: no capture logic; sd_in is unused; rdata_out is tied to 0 and rvalid_out to 0. All other timing is unchanged.

Test Plan:
1. DATABITS=16, NWORDS=4; start, words 0x8001, 0x1234, 0xFFFF, 0x0000 with wvalid always 1 -> each word gives 16 cycles of sde_out=1 with sd_out bits MSB first, one-cycle gaps between words, done_out pulses at cycle 4*17 after the first handshake, busy_out=0 after.
2. Model the chain as a 64-bit shift register preloaded with 0xA5A5_5A5A_0F0F_F0F0; full load (SCAN_READBACK_EN) -> rvalid_out pulses return 0xA5A5, 0x5A5A, 0x0F0F, 0xF0F0 in order. A second load returns the words written by the first.
3. wvalid_in low for 10 cycles in LOAD between words 2 and 3 -> sde_out stays 0, wready_out stays 1, the chain model is unchanged, and the load completes normally.
4. abort_in in the 7th SHIFT cycle of word 2 -> IDLE next cycle, sde_out=0, no rvalid_out/done_out; a new start_in then completes a clean 4-word load.
5. rst_n low in the middle of SHIFT -> all outputs 0 immediately (asynchronous); after release, start_in is required before wready_out=1.
6. start_in held high throughout the load, and pulsed again in the DONE cycle -> no restart; one done_out; IDLE reached and held with wready_out=0.
